// File: rtl/cache_trace_driver.sv
// cache_trace_driver: replays a loadable address trace into a direct-mapped
// cache tag model. It issues one address per cycle, samples the cache's hit
// output after a fixed latency, and accumulates hit/miss/access statistics
// for each run.
module cache_trace_driver #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DEPTH       = 64,
    parameter int PTR_WIDTH   = 6,
    parameter int CNT_WIDTH   = 16,
    parameter int HIT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [PTR_WIDTH-1:0]  load_idx,
    input  logic [ADDR_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic [PTR_WIDTH:0]    run_len,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_hit,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  access_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             state;
    logic [ADDR_WIDTH-1:0]  trace_mem [DEPTH];
    // ptr is one bit wider than an index so it can be compared against a
    // full-depth run length.
    logic [PTR_WIDTH:0]     ptr;
    logic [PTR_WIDTH:0]     run_len_q;
    // One bit per in-flight access; the top bit marks the access whose hit
    // is valid at this edge.
    logic [HIT_LATENCY-1:0] vld_pipe;
    logic [HIT_LATENCY-1:0] vld_next;
    logic                   idle_like;
    logic                   launch;
    logic                   push;
    logic                   sample;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    // A simultaneous load takes priority over start.
    assign launch    = idle_like && start && !load_en;
    // Every ISSUE edge is an edge where the cache captures a trace address.
    assign push      = (state == ST_ISSUE);
    assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign sample    = busy && vld_pipe[HIT_LATENCY-1];

    // Next pending-pipe contents: shift toward the sample point, insert this edge's capture.
    always_comb begin
        vld_next    = vld_pipe << 1;
        vld_next[0] = push;
    end

    // Trace memory: writable only while not running; deliberately not reset.
    always_ff @(posedge clk) begin
        if (idle_like && load_en)
            trace_mem[load_idx] <= load_data;
    end

    // Run sequencing: launch, issue one address per cycle, drain the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cache_addr <= '0;
            ptr        <= '0;
            run_len_q  <= '0;
            vld_pipe   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        vld_pipe  <= '0;
                        run_len_q <= run_len;
                        if (run_len == '0) begin
                            state <= ST_DONE;
                        end else begin
                            cache_addr <= trace_mem[0];
                            ptr        <= (PTR_WIDTH+1)'(1);
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    vld_pipe <= vld_next;
                    if (ptr < run_len_q) begin
                        cache_addr <= trace_mem[ptr[PTR_WIDTH-1:0]];
                        ptr        <= ptr + (PTR_WIDTH+1)'(1);
                    end else begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    vld_pipe <= vld_next;
                    // Leave on the edge that samples the last access.
                    if (vld_next == '0)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Statistics: cleared on launch, saturating increments on each sample.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            hit_count    <= '0;
            miss_count   <= '0;
            access_count <= '0;
        end else if (sample) begin
            access_count <= sat_inc(access_count);
            if (cache_hit)
                hit_count <= sat_inc(hit_count);
            else
                miss_count <= sat_inc(miss_count);
        end
    end

endmodule

// File: tb/tb_cache_trace_driver.sv
// Bench for cache_trace_driver: two instances (default counters and 2-bit
// counters) each drive a small direct-mapped cache stub. Expected counts come
// from an abstract cache model walked over the loaded trace.
module tb_cache_trace_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [5:0]  load_idx;
    logic [10:0] load_data;
    logic        start;
    logic [6:0]  run_len;

    logic [10:0] cache_addr, s_cache_addr;
    logic        cache_hit, s_cache_hit;
    logic        busy, done, s_busy, s_done;
    logic [15:0] hit_count, miss_count, access_count;
    logic [1:0]  s_hit, s_miss, s_acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_trace_driver dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_data(load_data), .start(start), .run_len(run_len),
        .cache_addr(cache_addr), .cache_hit(cache_hit), .busy(busy), .done(done),
        .hit_count(hit_count), .miss_count(miss_count), .access_count(access_count)
    );

    cache_trace_driver #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx),
        .load_data(load_data), .start(start), .run_len(run_len),
        .cache_addr(s_cache_addr), .cache_hit(s_cache_hit), .busy(s_busy), .done(s_done),
        .hit_count(s_hit), .miss_count(s_miss), .access_count(s_acc)
    );

    // Cache stubs: 32-byte lines, 16 lines, 2-bit tag; hit one edge after capture.
    logic [1:0] c1_tag [16];
    logic       c1_vld [16];
    logic [1:0] c2_tag [16];
    logic       c2_vld [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            c1_tag[i] = '0; c1_vld[i] = 1'b0;
            c2_tag[i] = '0; c2_vld[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cache_hit <= c1_vld[cache_addr[8:5]] && (c1_tag[cache_addr[8:5]] == cache_addr[10:9]);
        c1_vld[cache_addr[8:5]] <= 1'b1;
        c1_tag[cache_addr[8:5]] <= cache_addr[10:9];
    end

    always @(posedge clk) begin
        s_cache_hit <= c2_vld[s_cache_addr[8:5]] && (c2_tag[s_cache_addr[8:5]] == s_cache_addr[10:9]);
        c2_vld[s_cache_addr[8:5]] <= 1'b1;
        c2_tag[s_cache_addr[8:5]] <= s_cache_addr[10:9];
    end

    // Reference model of the main cache, plus the bench's copy of the trace.
    int          m_tag [16];
    bit          m_vld [16];
    logic [10:0] tr [64];
    logic [10:0] held;

    task automatic ref_access(input logic [10:0] a, output bit h);
        int line = int'(a) / 32 % 16;
        int tag  = int'(a) / 512;
        h = m_vld[line] && (m_tag[line] == tag);
        m_vld[line] = 1'b1;
        m_tag[line] = tag;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [10:0] a);
        load_en = 1'b1; load_idx = 6'(idx); load_data = a;
        tick;
        load_en = 1'b0;
        tr[idx] = a;
    endtask

    // Launch a run of n, optionally poking start/load mid-run, and check it.
    task automatic run_chk(input string tag, input int n, input bit disturb);
        int exp_h = 0, exp_m = 0, bcnt = 0, guard = 0;
        bit h, poke;
        for (int k = 0; k < n; k++) begin
            ref_access(tr[k], h);
            if (h) exp_h++; else exp_m++;
        end
        start = 1'b1; run_len = 7'(n);
        tick;
        start = 1'b0;
        while (!done && guard < 300) begin
            poke = 1'b0;
            if (busy) begin
                if (bcnt < n) chk({tag, "_addr"}, 32'(cache_addr), 32'(tr[bcnt]));
                bcnt++;
                if (disturb && bcnt == 2) begin
                    poke = 1'b1;
                    start = 1'b1; load_en = 1'b1; load_idx = '0; load_data = 11'h7FF;
                end
            end
            tick;
            guard++;
            if (poke) begin
                start = 1'b0; load_en = 1'b0;
            end
        end
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy_cycles"}, bcnt, (n == 0) ? 0 : n + 1);
        chk({tag, "_hits"}, 32'(hit_count), exp_h);
        chk({tag, "_misses"}, 32'(miss_count), exp_m);
        chk({tag, "_accesses"}, 32'(access_count), n);
        if (n > 0) held = tr[n-1];
        chk({tag, "_held_addr"}, 32'(cache_addr), 32'(held));
    endtask

    task automatic do_reset;
        bit h;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        ref_access(11'h000, h);
        held = '0;
    endtask

    initial begin
        bit h;
        rst = 1'b1; load_en = 1'b0; load_idx = '0; load_data = '0;
        start = 1'b0; run_len = '0;
        for (int i = 0; i < 16; i++) begin m_tag[i] = 0; m_vld[i] = 1'b0; end
        for (int i = 0; i < 64; i++) tr[i] = '0;

        do_reset;
        tick; tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(cache_addr), 0);
        chk("rst_hits", 32'(hit_count), 0);
        chk("rst_acc", 32'(access_count), 0);

        // Basic run: two hits on the reset-installed line 0, then two misses.
        load(0, 11'h000); load(1, 11'h000); load(2, 11'h020); load(3, 11'h200);
        run_chk("basic", 4, 1'b0);
        chk("basic_hits_abs", 32'(hit_count), 2);

        // Index-0 thrash, then the held address hits with counters frozen.
        load(0, 11'h000); load(1, 11'h200); load(2, 11'h000); load(3, 11'h200);
        run_chk("thrash", 4, 1'b0);
        chk("thrash_miss_abs", 32'(miss_count), 4);
        tick; tick;
        chk("held_hit", 32'(cache_hit), 1);
        chk("held_hits_frozen", 32'(hit_count), 0);
        chk("held_acc_frozen", 32'(access_count), 4);

        // Zero-length run goes straight to DONE.
        start = 1'b1; run_len = '0;
        tick;
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_acc", 32'(access_count), 0);
        chk("zero_addr", 32'(cache_addr), 32'(held));

        // start/load pokes while busy are ignored; rerun proves trace[0] kept.
        load(0, 11'h000); load(1, 11'h020); load(2, 11'h000); load(3, 11'h040); load(4, 11'h020);
        run_chk("poke", 5, 1'b1);
        run_chk("poke_rerun", 5, 1'b0);

        // Reset on the second ISSUE cycle.
        start = 1'b1; run_len = 7'd5;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_acc", 32'(access_count), 0);
        chk("midrst_miss", 32'(miss_count), 0);
        chk("midrst_addr", 32'(cache_addr), 0);
        ref_access(tr[0], h);
        ref_access(tr[1], h);
        ref_access(11'h000, h);
        held = '0;
        run_chk("after_rst", 5, 1'b0);

        // Randomized traces drawn from a few conflicting lines.
        for (int r = 0; r < 6; r++) begin
            int n = (r == 5) ? 64 : int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) begin
                logic [3:0] line;
                case ($urandom_range(0, 3))
                    0: line = 4'd0;
                    1: line = 4'd1;
                    2: line = 4'd2;
                    default: line = 4'd15;
                endcase
                load(i, {2'($urandom_range(0, 3)), line, 5'($urandom_range(0, 31))});
            end
            run_chk($sformatf("rand%0d", r), n, 1'b0);
        end

        // Saturation on the 2-bit-counter instance with line 2 pre-filled.
        load(0, 11'h040);
        run_chk("prefill", 1, 1'b0);
        for (int i = 0; i < 8; i++) load(i, 11'h040);
        run_chk("sat_main", 8, 1'b0);
        chk("sat_done", 32'(s_done), 1);
        chk("sat_hits", 32'(s_hit), 3);
        chk("sat_misses", 32'(s_miss), 0);
        chk("sat_acc", 32'(s_acc), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_trace_driver.md
Name: cache_trace_driver

Overview:
- CPU-side access initiator for the direct-mapped cache tag models (L1/L2).
- Holds a loadable address trace, issues one 11-bit address per cycle on the cache's `addr` input, and samples the cache's `hit` output after the cache's fixed latency.
- Accumulates hit, miss and access counts for one run.
- Used as the stimulus and statistics engine in cache-simulation benches and top levels.

Parameters:
- ADDR_WIDTH, 11, width of the cache address.
- DEPTH, 64, trace memory entries (power of two).
- PTR_WIDTH, 6, log2(DEPTH).
- CNT_WIDTH, 16, width of each statistics counter.
- HIT_LATENCY, 1, number of edges after the cache captures an address until its `hit` is sampled (min 1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write trace entry (honoured only in IDLE).
- load_idx  in  PTR_WIDTH  trace entry index.
- load_data  in  ADDR_WIDTH  address written to trace[load_idx].
- start  in  1  begin a run (sampled in IDLE only).
- run_len  in  PTR_WIDTH+1  accesses per run, 0..DEPTH; sampled with start.
- cache_addr  out  ADDR_WIDTH  registered address to cache `addr`.
- cache_hit  in  1  cache `hit` output.
- busy  out  1  high in ISSUE/DRAIN.
- done  out  1  high in DONE.
- hit_count  out  CNT_WIDTH  hits this run.
- miss_count  out  CNT_WIDTH  misses this run.
- access_count  out  CNT_WIDTH  accesses sampled this run.

Behaviour:
- Reset:
  - state=IDLE; cache_addr=0; busy=0; done=0; all counters=0; ptr=0; pending pipe cleared.
  - Trace memory is not cleared.
- The cache has no enable and captures `addr` every edge. Outside ISSUE, cache_addr holds its last value, so the cache sees repeat accesses to one line. Repeat accesses to one line are idempotent. After reset, line index 0 / tag 0 becomes valid through this path; benches account for it.
- IDLE:
  - load_en writes trace[load_idx] at the edge.
  - start=1 with load_en=0: clear all counters, latch run_len, cache_addr<=trace[0], ptr<=1, go to ISSUE.
  - With run_len=0: counters are cleared, cache_addr is unchanged, and the state goes straight to DONE.
  - start together with load_en: start is ignored; the load is performed.
- ISSUE:
  - Each address is presented for exactly one cycle.
  - At each edge: push pending=1 into the HIT_LATENCY-deep pipe for the address the cache captures at this edge.
  - If ptr<run_len: cache_addr<=trace[ptr], ptr++. Otherwise cache_addr holds and the state goes to DRAIN.
- Sampling (ISSUE/DRAIN):
  - At each edge where the pipe output is 1: access_count++; hit_count++ if cache_hit else miss_count++.
  - For HIT_LATENCY=1, address k is presented after edge E_k, captured at E_{k+1}, and sampled at E_{k+2}.
- DRAIN:
  - Wait until the pipe is empty.
  - The state goes to DONE at the same edge that samples the last access.
  - busy is high for exactly run_len+HIT_LATENCY cycles after the start edge (run_len≥1).
- DONE:
  - done=1; counters hold.
  - start relaunches (counters clear); load_en is accepted as in IDLE.
- Other rules:
  - start and load_en while busy are ignored.
  - Counters saturate at 2^CNT_WIDTH−1 and never wrap. hit_count+miss_count==access_count whenever no counter is saturated.
  - rst mid-run: next cycle all outputs take reset values and in-flight samples are discarded.

Test Plan:
- Reset, idle ≥2 cycles. Load trace {0x000,0x000,0x020,0x200}, run_len=4, start → busy exactly 5 cycles, then done=1. Counts: hit=2, miss=2, access=4. cache_addr holds 0x200.
- After the previous scenario, load {0x000,0x200,0x000,0x200}, run_len=4 → index-0 thrash gives hit=0, miss=4. The final held 0x200 then shows a cache hit with no counter change.
- start with run_len=0 → done=1 at the next edge. Counters 0, busy never high, cache_addr unchanged.
- Pulse start and load_en(idx 0, 0x7FF) during ISSUE → both ignored; counts match an undisturbed run. A rerun confirms trace[0] is unchanged.
- Assert rst on the 2nd ISSUE cycle → next cycle busy=0, done=0, counters 0, cache_addr=0. A fresh start then completes normally.
- CNT_WIDTH=2, trace of 8× 0x040 with the line pre-filled → hit_count saturates at 3, miss_count=0, access_count=3.
